// File: rtl/vga_timing_recovery_if.sv
// Sync/blank input set from a VGA-style source plus the recovered timing
// seen by downstream capture/overlay logic.
interface vga_timing_recovery_if #(
  parameter int WIDTH = 10
);
  logic             hsync;
  logic             vsync;
  logic             hblank;
  logic             vblank;
  logic [WIDTH-1:0] hcount;
  logic [WIDTH-1:0] vcount;
  logic             active;
  logic [WIDTH-1:0] h_total;
  logic [WIDTH-1:0] v_total;
  logic             locked;
  logic             timing_err;

  modport master (
    output hsync,
    output vsync,
    output hblank,
    output vblank,
    input  hcount,
    input  vcount,
    input  active,
    input  h_total,
    input  v_total,
    input  locked,
    input  timing_err
  );

  modport slave (
    input  hsync,
    input  vsync,
    input  hblank,
    input  vblank,
    output hcount,
    output vcount,
    output active,
    output h_total,
    output v_total,
    output locked,
    output timing_err
  );
endinterface

// File: rtl/vga_timing_recovery.sv
// Sink-side VGA timing recovery: measures line/frame length from incoming
// syncs, regenerates active-aligned coordinates and tracks lock.
module vga_timing_recovery #(
  parameter int WIDTH       = 10,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_timing_recovery_if.slave  bus
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] PRE = MAX - WIDTH'(1);
  localparam logic [MW-1:0]    LF  = MW'(LOCK_FRAMES);

  localparam logic [1:0] S_SEARCH  = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  logic             r_hs_d;
  logic             r_vs_d;
  logic             r_hb_d;
  logic             r_vb_d;

  logic [WIDTH-1:0] r_pix;
  logic [WIDTH-1:0] r_lin;
  logic [WIDTH-1:0] r_h_len;
  logic [1:0]       r_hs_n;
  logic [1:0]       r_vs_n;

  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_vcnt;
  logic             r_vpend;
  logic             r_active;

  logic [1:0]       r_state;
  logic [MW-1:0]    r_match;
  logic [WIDTH-1:0] r_h_ref;
  logic [WIDTH-1:0] r_v_ref;
  logic             r_locked;
  logic             r_err;

  logic             w_hs_rise;
  logic             w_vs_rise;
  logic             w_hb_fall;
  logic             w_vb_fall;
  logic [WIDTH-1:0] w_h_meas;
  logic [WIDTH-1:0] w_h_now;
  logic [WIDTH-1:0] w_v_len;
  logic             w_h_valid;
  logic             w_timeout;
  logic             w_h_bad;
  logic             w_v_bad;
  logic             w_track;
  logic             w_fail;
  logic             w_start;
  logic             w_frame_ok;
  logic [MW-1:0]    w_match_inc;
  logic [1:0]       w_state_nxt;
  logic [MW-1:0]    w_match_nxt;

  assign w_hs_rise = bus.hsync & ~r_hs_d;
  assign w_vs_rise = bus.vsync & ~r_vs_d;
  assign w_hb_fall = ~bus.hblank & r_hb_d;
  assign w_vb_fall = ~bus.vblank & r_vb_d;

  assign w_h_meas = r_pix + WIDTH'(1);
  assign w_h_now  = w_hs_rise ? w_h_meas : r_h_len;

  // A line start coincident with vsync closes the ending frame.
  assign w_v_len = (r_lin == MAX) ? MAX :
                   r_lin + WIDTH'(w_hs_rise);

  assign w_h_valid = r_hs_n[1];
  assign w_timeout = ~w_hs_rise & (r_pix == PRE);
  assign w_h_bad   = w_hs_rise & (w_h_meas != r_h_ref);
  assign w_v_bad   = w_vs_rise & (w_v_len != r_v_ref);
  assign w_track   = (r_state != S_SEARCH);

  assign w_fail = w_track & (w_h_bad | w_v_bad | w_timeout);

  assign w_start = (r_state == S_SEARCH) & w_vs_rise &
                   w_h_valid & (r_vs_n != 2'd0);

  assign w_frame_ok = w_track & w_vs_rise & ~w_fail;

  assign w_match_inc = (r_match == LF) ? LF : r_match + MW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    unique case (1'b1)
      w_fail: begin
        w_state_nxt = S_SEARCH;
        w_match_nxt = '0;
      end
      w_start: begin
        w_state_nxt = S_MEASURE;
        w_match_nxt = '0;
      end
      w_frame_ok: begin
        w_match_nxt = w_match_inc;
        if (w_match_inc == LF) w_state_nxt = S_LOCKED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_hb_d <= 1'b0;
      r_vb_d <= 1'b0;
    end else begin
      r_hs_d <= bus.hsync;
      r_vs_d <= bus.vsync;
      r_hb_d <= bus.hblank;
      r_vb_d <= bus.vblank;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix   <= '0;
      r_h_len <= '0;
      r_lin   <= '0;
    end else begin
      if (w_hs_rise) begin
        r_pix   <= '0;
        r_h_len <= w_h_meas;
      end else if (r_pix != MAX) begin
        r_pix <= r_pix + WIDTH'(1);
      end
      if (w_vs_rise) begin
        r_lin <= '0;
      end else if (w_hs_rise && r_lin != MAX) begin
        r_lin <= r_lin + WIDTH'(1);
      end
    end
  end

  // Edge counters saturate at 2: first edge only primes the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hs_n <= 2'd0;
      r_vs_n <= 2'd0;
    end else if (w_fail) begin
      r_hs_n <= 2'd0;
      r_vs_n <= 2'd0;
    end else begin
      if (w_hs_rise && r_hs_n != 2'd2) r_hs_n <= r_hs_n + 2'd1;
      if (w_vs_rise && r_vs_n != 2'd2) r_vs_n <= r_vs_n + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_vpend  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_active <= ~bus.hblank & ~bus.vblank;
      if (w_hb_fall) begin
        r_hcnt <= '0;
      end else if (r_hcnt != MAX) begin
        r_hcnt <= r_hcnt + WIDTH'(1);
      end
      if (w_hb_fall) begin
        if (r_vpend || w_vb_fall) begin
          r_vcnt  <= '0;
          r_vpend <= 1'b0;
        end else if (r_vcnt != MAX) begin
          r_vcnt <= r_vcnt + WIDTH'(1);
        end
      end else if (w_vb_fall) begin
        r_vpend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_SEARCH;
      r_match  <= '0;
      r_h_ref  <= '0;
      r_v_ref  <= '0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_match  <= w_match_nxt;
      r_locked <= (w_state_nxt == S_LOCKED);
      r_err    <= w_fail;
      if (w_start) begin
        r_h_ref <= w_h_now;
        r_v_ref <= w_v_len;
      end
    end
  end

  assign bus.hcount     = r_hcnt;
  assign bus.vcount     = r_vcnt;
  assign bus.active     = r_active;
  assign bus.h_total    = r_h_ref;
  assign bus.v_total    = r_v_ref;
  assign bus.locked     = r_locked;
  assign bus.timing_err = r_err;

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Bench for vga_timing_recovery on a reduced raster (80 clk x 21 lines)
// so lock, slip, timeout and reset sequences fit a short run.
module tb_vga_timing_recovery;

  localparam int W   = 10;
  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VA  = 12;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 5;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int HS0 = HA + HFP;
  localparam int VS0 = VA + VFP;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_recovery_if #(.WIDTH(W)) bus ();

  vga_timing_recovery #(
    .WIDTH(W),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit act;
    int hc;
    int vc;
  } exp_t;

  typedef struct {
    int x;
    int y;
    bit act;
    int hc;
    int vc;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  int n_chk, n_pass;
  int vs_cnt, err_cnt, lock_vs, lock_on_vs;
  int err_x, err_y, err_lk, err_prev;
  int sb_bad, sb_fx, sb_fy;
  bit prev_vs, prev_lk;
  bit sb_on, vec_on, coinc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " hcount"}, bus.hcount, 0);
    chk({tag, " vcount"}, bus.vcount, 0);
    chk({tag, " h_total"}, bus.h_total, 0);
    chk({tag, " v_total"}, bus.v_total, 0);
    chk({tag, " active"}, bus.active, 0);
    chk({tag, " locked"}, bus.locked, 0);
    chk({tag, " timing_err"}, bus.timing_err, 0);
  endtask

  task automatic clr_mon();
    vs_cnt     = 0;
    err_cnt    = 0;
    lock_vs    = -1;
    lock_on_vs = 0;
  endtask

  task automatic px(input int x, input int y);
    bit hs, vs, hb, vb, vs_rose, bad;
    exp_t e;
    hb = (x >= HA);
    hs = (x >= HS0) && (x < HS0 + HSW);
    if (coinc) begin
      vs = (y == VS0 && x >= HS0) || (y > VS0 && y < VS0 + VSW) ||
           (y == VS0 + VSW && x < HS0);
      vb = (y >= VA || (y == VA - 1 && x >= HA)) &&
           !(y == VT - 1 && x >= HA);
    end else begin
      vs = (y >= VS0) && (y < VS0 + VSW);
      vb = (y >= VA);
    end
    bus.hsync  = hs;
    bus.vsync  = vs;
    bus.hblank = hb;
    bus.vblank = vb;
    vs_rose = vs && !prev_vs;
    prev_vs = vs;
    if (vs_rose) vs_cnt++;
    if (sb_on) begin
      e.act = !hb && !vb;
      e.hc  = x;
      e.vc  = y;
      sb_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (bus.timing_err) begin
      if (err_cnt == 0) begin
        err_x    = x;
        err_y    = y;
        err_lk   = bus.locked;
        err_prev = prev_lk;
      end
      err_cnt++;
    end
    if (bus.locked && !prev_lk && lock_vs < 0) begin
      lock_vs    = vs_cnt;
      lock_on_vs = vs_rose;
    end
    prev_lk = bus.locked;
    if (sb_on && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      bad = (bus.active !== e.act);
      if (e.act && (int'(bus.hcount) != e.hc ||
                    int'(bus.vcount) != e.vc)) bad = 1'b1;
      if (bad) begin
        if (sb_bad == 0) begin
          sb_fx = x;
          sb_fy = y;
        end
        sb_bad++;
      end
    end
    if (vec_on) begin
      for (int i = 0; i < $size(vecs); i++) begin
        if (vecs[i].x == x && vecs[i].y == y) begin
          chk($sformatf("vec%0d active", i), bus.active, vecs[i].act);
          if (vecs[i].act) begin
            chk($sformatf("vec%0d hcount", i), bus.hcount, vecs[i].hc);
            chk($sformatf("vec%0d vcount", i), bus.vcount, vecs[i].vc);
          end
        end
      end
    end
  endtask

  task automatic line(input int y, input bit stretch);
    for (int x = 0; x < HT; x++) px(x, y);
    if (stretch) px(HT - 1, y);
  endtask

  task automatic frame(input int st_line);
    for (int y = 0; y < VT; y++) line(y, y == st_line);
  endtask

  task automatic chk_sb(input string nm);
    if (sb_bad != 0)
      $display("  first bad pixel x=%0d y=%0d", sb_fx, sb_fy);
    chk(nm, sb_bad, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 1'b1, 0, 0};
    vecs[1] = '{5, 0, 1'b1, 5, 0};
    vecs[2] = '{63, 0, 1'b1, 63, 0};
    vecs[3] = '{64, 0, 1'b0, 0, 0};
    vecs[4] = '{0, 1, 1'b1, 0, 1};
    vecs[5] = '{30, 5, 1'b1, 30, 5};
    vecs[6] = '{63, 11, 1'b1, 63, 11};
    vecs[7] = '{0, 12, 1'b0, 0, 0};
    vecs[8] = '{70, 20, 1'b0, 0, 0};

    n_chk   = 0;
    n_pass  = 0;
    prev_vs = 1'b0;
    prev_lk = 1'b0;
    sb_on   = 1'b0;
    vec_on  = 1'b0;
    coinc   = 1'b0;
    sb_bad  = 0;
    sb_fx   = 0;
    sb_fy   = 0;
    err_x   = 0;
    err_y   = 0;
    err_lk  = 0;
    err_prev = 0;
    bus.hsync  = 1'b0;
    bus.vsync  = 1'b0;
    bus.hblank = 1'b0;
    bus.vblank = 1'b0;
    clr_mon();

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;

    // lock from reset
    repeat (4) frame(-1);
    chk("lock vs index", lock_vs, 4);
    chk("lock on vs edge", lock_on_vs, 1);
    chk("lock no error", err_cnt, 0);
    chk("locked", bus.locked, 1);
    chk("h_total", bus.h_total, HT);
    chk("v_total", bus.v_total, VT);

    // coordinate recovery
    sb_bad = 0;
    sb_on  = 1'b1;
    vec_on = 1'b1;
    frame(-1);
    sb_on  = 1'b0;
    vec_on = 1'b0;
    chk_sb("scoreboard normal frame");
    chk("clean frame no error", err_cnt, 0);

    // one stretched line
    clr_mon();
    frame(10);
    chk("stretch err pulses", err_cnt, 1);
    chk("stretch err x", err_x, HS0);
    chk("stretch err y", err_y, 11);
    chk("stretch locked before", err_prev, 1);
    chk("stretch locked with err", err_lk, 0);
    chk("stretch unlocked", bus.locked, 0);
    repeat (3) frame(-1);
    chk("relock vs index", lock_vs, 4);
    chk("relock on vs edge", lock_on_vs, 1);
    chk("relock err pulses", err_cnt, 1);
    chk("relocked", bus.locked, 1);

    // hsync stall
    clr_mon();
    for (int y = 0; y < 10; y++) line(y, 1'b0);
    repeat (1100) px(HT - 1, 9);
    chk("timeout err pulses", err_cnt, 1);
    chk("timeout unlocked", bus.locked, 0);
    for (int y = 10; y < VT; y++) line(y, 1'b0);
    chk("search no error", err_cnt, 1);
    repeat (3) frame(-1);
    chk("timeout relock vs index", lock_vs, 4);
    chk("timeout relocked", bus.locked, 1);

    // async reset mid-frame, then coincident hsync/vsync
    for (int y = 0; y < 5; y++) line(y, 1'b0);
    for (int x = 0; x < 20; x++) px(x, 5);
    #2 rst = 1'b0;
    #1 chk_zero("async reset");
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    coinc   = 1'b1;
    prev_lk = 1'b0;
    clr_mon();
    for (int x = 20; x < HT; x++) px(x, 5);
    for (int y = 6; y < VT; y++) line(y, 1'b0);
    repeat (3) frame(-1);
    chk("post-reset lock vs index", lock_vs, 4);
    chk("post-reset lock on vs", lock_on_vs, 1);
    chk("coincident v_total", bus.v_total, VT);
    chk("coincident h_total", bus.h_total, HT);
    chk("coincident no error", err_cnt, 0);

    // vblank falling during hblank
    sb_bad = 0;
    sb_on  = 1'b1;
    frame(-1);
    sb_on  = 1'b0;
    chk_sb("scoreboard early vblank frame");
    chk("early vblank locked", bus.locked, 1);
    chk("early vblank no error", err_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_recovery.md
# vga_timing_recovery

Sink-side counterpart of the sync generator. It watches an incoming hsync/vsync/hblank/vblank set on the pixel clock, measures line and frame length, and regenerates pixel coordinates aligned to the active region. It declares lock once the timing stays stable and flags any deviation. It sits at the input of capture, overlay and monitor blocks, which consume its hcount/vcount/active/locked outputs.

## Interface
- WIDTH, 10, width of all counters and measurement registers
- LOCK_FRAMES, 2, consecutive matching frames needed after the first measurement before locked asserts (≥1)
- clk  in  1  pixel clock; all inputs synchronous to it
- rst  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active-high
- vsync  in  1  vertical sync, active-high
- hblank  in  1  horizontal blank, active-high
- vblank  in  1  vertical blank, active-high
- hcount  out  WIDTH  recovered column; 0 on first active pixel of a line
- vcount  out  WIDTH  recovered row; 0 on first active line of a frame
- active  out  1  registered !hblank && !vblank
- h_total  out  WIDTH  locked line length in clocks (hsync rise to hsync rise)
- v_total  out  WIDTH  locked frame length in lines (hsync rises between vsync rises)
- locked  out  1  timing stable
- timing_err  out  1  one-cycle pulse on mismatch or timeout

## Operation
- Edge detect:
  - Register hsync/vsync/hblank/vblank once.
  - hs_rise = hsync & ~hsync_d.
  - vs_rise = vsync & ~vsync_d.
  - hb_fall = ~hblank & hblank_d.
  - vb_fall = ~vblank & vblank_d.
- Pixel measure counter pix:
  - 0 on hs_rise, else +1, saturating at 2^WIDTH−1.
  - On hs_rise, h_len <= pix+1. h_valid is set on the second hs_rise since reset or entry to SEARCH.
- Line measure counter lin:
  - On vs_rise, v_len <= lin + hs_rise and lin <= 0. Otherwise lin += hs_rise, saturating.
  - v_valid is set on the second vs_rise since reset or entry to SEARCH.
- hcount:
  - 0 on hb_fall, else +1, saturating at 2^WIDTH−1.
- vcount:
  - vb_fall sets vpend; vcount does not change on vb_fall.
  - On hb_fall: if vpend (or vb_fall in the same cycle), vcount <= 0 and vpend clears; else vcount +1, saturating.
- FSM states: SEARCH, MEASURE, LOCKED.
  - SEARCH → MEASURE on vs_rise when h_valid and the v_len being captured that cycle is the second or later. At entry, h_ref <= current h_len, v_ref <= captured v_len, match_cnt <= 0.
  - MEASURE: each hs_rise compares the new h_len with h_ref. Each vs_rise compares the captured v_len with v_ref.
    - All match: match_cnt +1. When match_cnt reaches LOCK_FRAMES → LOCKED.
  - LOCKED: same compares.
  - Any mismatch in MEASURE or LOCKED: pulse timing_err, go to SEARCH, clear h_valid, v_valid and match_cnt.
  - Timeout in any state except SEARCH: pix saturates (no hs_rise for 2^WIDTH−1 clocks) → pulse timing_err, go to SEARCH. timing_err pulses once per saturation event, not every cycle.
  - In SEARCH, mismatch checks are disabled and timing_err never pulses.
- Outputs:
  - h_total/v_total = h_ref/v_ref.
  - locked = (state == LOCKED).

## Timing
- Reset values:
  - hcount, vcount, h_total, v_total = 0.
  - active, locked, timing_err = 0.
  - State SEARCH; all internal counters, flags and delayed copies cleared.
- Reset is asynchronous; assertion mid-frame clears everything immediately. After release the block needs full new measurements.
- All outputs are registered.
  - hcount reads 0 in the cycle after the first clock edge sampling hblank=0 following hblank=1. This is one cycle behind a generator's own hcount.
  - active lags the inputs by one cycle.
- A hs_rise coincident with vs_rise counts toward the ending frame.
- Mismatch: timing_err is high for exactly one cycle, in the cycle after the offending edge is sampled. locked drops in that same cycle.
- locked asserts in the cycle after the vs_rise that brings match_cnt to LOCK_FRAMES.

## Test plan
- Generator drives 640x480 timing (800 clk/line, 521 lines) from reset → h_total=800, v_total=521. locked rises the cycle after the 4th vs_rise (LOCK_FRAMES=2). timing_err stays 0.
- Locked, then one line stretched to 801 clocks → timing_err pulses once and locked falls one cycle after that hs_rise. Relock after 3 further clean vs_rises.
- Locked, then hsync held low 1023 clocks → one timing_err pulse at saturation, state SEARCH, locked=0.
- Active region → hcount steps 0..639 while active=1. vcount reads 0 on the first line after vblank falls and reaches 479 on the last active line.
- rst asserted mid-frame while locked → all outputs 0 asynchronously. After release, locked returns only after 4 vs_rises.
- vs_rise forced coincident with hs_rise → v_len includes that line (v_total=521 on a 521-line frame).
